// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
// The BEST_TIME_EN build option lives in reaction_timer_ctrl; nothing here depends on it.
package reaction_pkg;

    localparam int WIDTH_DEF   = 14;
    localparam int TIMEOUT_DEF = 5000;

    // Wide all-ones value, truncated to WIDTH where it is used.
    localparam logic [63:0] BEST_RESET = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_GO     = 3'd2,
        ST_RESULT = 3'd3,
        ST_EARLY  = 3'd4
    } state_t;

    // States in which a Start pulse opens a new round.
    function automatic logic accepts_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_RESULT) || (s == ST_EARLY);
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_ms_counter.sv
// Millisecond counter with clear and tick enable, plus a terminal-compare flag.
// Shared between the WAIT delay and the GO response/timeout measurement.
module ms_counter #(
    parameter int WIDTH = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_next;

    // One extra bit so count+1 can never alias to a small value.
    assign w_next     = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign o_terminal = (w_next >= {1'b0, i_limit});
    assign o_count    = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= w_next[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: random dark delay, lit LED, measured response in ms.
// Optional macro BEST_TIME_EN adds the o_best_time register/port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, waiting for Start
// ST_WAIT   | LED dark, counting the random delay in ticks
// ST_GO     | LED lit, counting the player's response time
// ST_RESULT | round closed by React or by timeout, result held
// ST_EARLY  | player pressed during WAIT, round aborted
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int TIMEOUT_MS = TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic             i_react,
    input  logic [WIDTH-1:0] i_random_value,
`ifdef BEST_TIME_EN
    output logic [WIDTH-1:0] o_best_time,
`endif
    output logic             o_led,
    output logic [WIDTH-1:0] o_reaction_time,
    output logic             o_valid,
    output logic             o_early,
    output logic             o_timeout
);

    localparam logic [WIDTH-1:0] TIMEOUT_L = WIDTH'(TIMEOUT_MS);

    state_t           r_state;
    logic [WIDTH-1:0] r_delay;
    logic [WIDTH-1:0] r_reaction_time;
    logic             r_led;
    logic             r_valid;
    logic             r_early;
    logic             r_timeout;

    logic             w_clear;
    logic             w_inc;
    logic [WIDTH-1:0] w_limit;
    logic [WIDTH-1:0] w_count;
    logic             w_term;
    logic [WIDTH-1:0] w_react_time;

    ms_counter #(.WIDTH(WIDTH)) u_ms_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_clear),
        .i_tick     (w_inc),
        .i_limit    (w_limit),
        .o_count    (w_count),
        .o_terminal (w_term)
    );

    // A Tick arriving together with React still counts toward the result.
    assign w_react_time = w_count + {{(WIDTH-1){1'b0}}, i_tick};

    always_comb begin
        w_clear = 1'b0;
        w_inc   = 1'b0;
        w_limit = (r_state == ST_GO) ? TIMEOUT_L : r_delay;
        case (r_state)
            ST_WAIT: begin
                if (!i_react && i_tick) begin
                    if (w_term) w_clear = 1'b1;
                    else        w_inc   = 1'b1;
                end
            end
            ST_GO: begin
                if (!i_react && i_tick && !w_term) w_inc = 1'b1;
            end
            default: begin
                if (i_start && accepts_start(r_state)) w_clear = 1'b1;
            end
        endcase
    end

`ifdef BEST_TIME_EN
    logic [WIDTH-1:0] r_best_time;
    assign o_best_time = r_best_time;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_delay         <= '0;
            r_reaction_time <= '0;
            r_led           <= 1'b0;
            r_valid         <= 1'b0;
            r_early         <= 1'b0;
            r_timeout       <= 1'b0;
`ifdef BEST_TIME_EN
            r_best_time     <= WIDTH'(BEST_RESET);
`endif
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (i_react) begin
                        r_state <= ST_EARLY;
                        r_early <= 1'b1;
                    end else if (i_tick && w_term) begin
                        r_state <= ST_GO;
                        r_led   <= 1'b1;
                    end
                end
                ST_GO: begin
                    if (i_react) begin
                        r_state         <= ST_RESULT;
                        r_led           <= 1'b0;
                        r_valid         <= 1'b1;
                        r_reaction_time <= w_react_time;
`ifdef BEST_TIME_EN
                        if (w_react_time < r_best_time) r_best_time <= w_react_time;
`endif
                    end else if (i_tick && w_term) begin
                        r_state         <= ST_RESULT;
                        r_led           <= 1'b0;
                        r_valid         <= 1'b1;
                        r_timeout       <= 1'b1;
                        r_reaction_time <= TIMEOUT_L;
                    end
                end
                ST_IDLE, ST_RESULT, ST_EARLY: begin
                    // Start outranks a same-cycle React here; React alone is ignored.
                    if (i_start) begin
                        r_state         <= ST_WAIT;
                        r_delay         <= i_random_value;
                        r_reaction_time <= '0;
                        r_led           <= 1'b0;
                        r_valid         <= 1'b0;
                        r_early         <= 1'b0;
                        r_timeout       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_led   <= 1'b0;
                end
            endcase
        end
    end

    assign o_led           = r_led;
    assign o_reaction_time = r_reaction_time;
    assign o_valid         = r_valid;
    assign o_early         = r_early;
    assign o_timeout       = r_timeout;

endmodule
